// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : 5-stage pipeline stall/flush controller with stall and flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_load,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic        br_taken,
    input  logic        clr_counts,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        bubble_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BUBBLE  = 2'd1,
        FLUSHED = 2'd2,
        FREEZE  = 2'd3
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Control vector: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    //                  bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem}
    localparam logic [8:0] c_CTRL_FROZEN = 9'b00000_0_000;
    localparam logic [8:0] c_CTRL_FLUSH  = 9'b11111_0_111;
    localparam logic [8:0] c_CTRL_BUBBLE = 9'b00111_1_000;
    localparam logic [8:0] c_CTRL_RUN    = 9'b11111_0_000;

    state_t      r_state;
    state_t      r_ret;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    state_t      w_eff;
    state_t      w_next;
    logic [8:0]  w_ctrl;
    logic        w_stall_inc;
    logic        w_flush_inc;

    always_comb begin
        w_eff       = (r_state == FREEZE) ? r_ret : r_state;
        w_next      = RUN;
        w_ctrl      = c_CTRL_RUN;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (dcache_stall) begin
            w_next      = FREEZE;
            w_ctrl      = c_CTRL_FROZEN;
            w_stall_inc = 1'b1;
        end else if (br_taken) begin
            w_next      = FLUSHED;
            w_ctrl      = c_CTRL_FLUSH;
            w_flush_inc = 1'b1;
        end else if (icache_stall) begin
            w_next      = RUN;
            w_ctrl      = c_CTRL_BUBBLE;
            w_stall_inc = 1'b1;
        end else if (stall_load && (w_eff == RUN)) begin
            // Only one bubble per hazard: BUBBLE/FLUSHED suppress a repeated request.
            w_next      = BUBBLE;
            w_ctrl      = c_CTRL_BUBBLE;
            w_stall_inc = 1'b1;
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
            bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem} =
           rst_n ? w_ctrl : 9'b0;

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_ret          <= RUN;
            r_stall_cycles <= 16'd0;
            r_flush_count  <= 16'd0;
        end else begin
            r_state <= w_next;
            // While frozen the effective state is ret itself, so this also holds it.
            if (dcache_stall)
                r_ret <= w_eff;

            if (clr_counts)
                r_stall_cycles <= 16'd0;
            else if (w_stall_inc && (r_stall_cycles != c_CNT_MAX))
                r_stall_cycles <= r_stall_cycles + 16'd1;

            if (clr_counts)
                r_flush_count <= 16'd0;
            else if (w_flush_inc && (r_flush_count != c_CNT_MAX))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

endmodule

`default_nettype wire
